// File: rtl/mmu_pkg.sv
// Shared MMU access-control types: FSM state encoding and fault status bit indices.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mmu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2,
        ST_BERR = 2'd3
    } mmu_state_t;

    // Bit positions inside the fault status register
    localparam int FLT_NO_READ = 0;
    localparam int FLT_WP      = 1;
    localparam int FLT_NX      = 2;
    localparam int FLT_PRIV    = 3;
    localparam int FLT_BADREQ  = 4;
    localparam int FLT_OVF     = 5;

    // Width of the permission-check fault field and of the full status register
    localparam int FLT_W = 5;
    localparam int FSR_W = 6;

endpackage

// File: rtl/mmu_fault_log.sv
// Fault logger: captures first unserviced fault (status + address), flags overflow, counts denials.
// Latency: capture/clear visible one cycle after the denied accept or clear strobe.
// Backpressure: none; accepts a denial event every cycle.
module mmu_fault_log
    import mmu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              deny_vld,
    input  logic [FLT_W-1:0]  flt_dat,
    input  logic [ADDR_W-1:0] flt_addr,
    input  logic              fsr_clr,
    output logic [FSR_W-1:0]  fsr,
    output logic [ADDR_W-1:0] far,
    output logic              fault_pend,
    output logic [CNT_W-1:0]  fault_cnt
);

    logic [FSR_W-1:0]  fsr_q,  fsr_d;
    logic [ADDR_W-1:0] far_q,  far_d;
    logic              pend_q, pend_d;
    logic [CNT_W-1:0]  cnt_q,  cnt_d;

    // Capture/overflow/clear priority: a new denial beats a coincident clear, and a
    // clear in that same cycle means the new fault is treated as the first one.
    always_comb begin
        fsr_d  = fsr_q;
        far_d  = far_q;
        pend_d = pend_q;
        if (deny_vld) begin
            if (!pend_q || fsr_clr) begin
                fsr_d  = {1'b0, flt_dat};
                far_d  = flt_addr;
                pend_d = 1'b1;
            end else begin
                fsr_d[FLT_OVF] = 1'b1;
            end
        end else if (fsr_clr) begin
            fsr_d  = '0;
            far_d  = '0;
            pend_d = 1'b0;
        end
    end

    // Denial counter saturates at all-ones; software clear does not touch it
    always_comb begin
        cnt_d = cnt_q;
        if (deny_vld && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Fault log state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsr_q  <= '0;
            far_q  <= '0;
            pend_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            fsr_q  <= fsr_d;
            far_q  <= far_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign fsr        = fsr_q;
    assign far        = far_q;
    assign fault_pend = pend_q;
    assign fault_cnt  = cnt_q;

endmodule

// File: rtl/mmu_access_ctl.sv
// MMU access controller: forwards permitted CPU accesses to the bus, returns bus errors for denied ones.
// Latency: accept-to-done >= 2 cycles (1 + bus wait); accept-to-berr 1 cycle.
// Backpressure: acc_ready only in IDLE; bus_addr/bus_we held until bus_ready handshake.
module mmu_access_ctl
    import mmu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              acc_valid,
    output logic              acc_ready,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic              acc_r,
    input  logic              acc_w,
    input  logic              acc_x,
    input  logic              pc_allow,
    input  logic [FLT_W-1:0]  pc_fault,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_we,
    output logic              acc_done,
    output logic              acc_berr,
    output logic [FSR_W-1:0]  fsr,
    output logic [ADDR_W-1:0] far,
    output logic              fault_pend,
    output logic [CNT_W-1:0]  fault_cnt,
    input  logic              fsr_clr
);

    mmu_state_t        state_q, state_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic              bus_we_q, bus_we_d;
    logic              accept, deny, grant;

    // Read/fetch class is resolved by the external permission checker; only the
    // write bit matters to the bus side.
    logic unused_class;
    assign unused_class = acc_r ^ acc_x;

    // Accept classification; bad_req overrides any allow from the checker
    always_comb begin
        accept = acc_valid && (state_q == ST_IDLE);
        deny   = accept && (!pc_allow || pc_fault[FLT_BADREQ]);
        grant  = accept && !deny;
    end

    // Next-state and bus request capture; inputs are only looked at in IDLE
    always_comb begin
        state_d    = state_q;
        bus_addr_d = bus_addr_q;
        bus_we_d   = bus_we_q;
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    state_d    = ST_BUS;
                    bus_addr_d = acc_addr;
                    bus_we_d   = acc_w;
                end else if (deny) begin
                    state_d = ST_BERR;
                end
            end
            ST_BUS:  if (bus_ready) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            ST_BERR: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and registered bus request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bus_addr_q <= '0;
            bus_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bus_addr_q <= bus_addr_d;
            bus_we_q   <= bus_we_d;
        end
    end

    // Handshake and completion strobes decode straight from the state register
    assign acc_ready = (state_q == ST_IDLE);
    assign bus_valid = (state_q == ST_BUS);
    assign acc_done  = (state_q == ST_DONE);
    assign acc_berr  = (state_q == ST_BERR);
    assign bus_addr  = bus_addr_q;
    assign bus_we    = bus_we_q;

    mmu_fault_log #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_fault_log (
        .clk        (clk),
        .rst_n      (rst_n),
        .deny_vld   (deny),
        .flt_dat    (pc_fault),
        .flt_addr   (acc_addr),
        .fsr_clr    (fsr_clr),
        .fsr        (fsr),
        .far        (far),
        .fault_pend (fault_pend),
        .fault_cnt  (fault_cnt)
    );

endmodule
